// File: rtl/store_monitor_if.sv
// Store-stream and reader handshake bundle for store_monitor.
// Master drives stores and rd_ready; slave presents the record FIFO and verdicts.
interface store_monitor_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          memwrite;
  logic [31:0]   dataadr;
  logic [31:0]   writedata;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   store_count;
  logic          done;
  logic          pass;
  logic          fail;

  modport master (
    output memwrite, dataadr, writedata, rd_ready,
    input  rd_valid, rd_addr, rd_data, count,
    input  overflow, store_count, done, pass, fail
  );

  modport slave (
    input  memwrite, dataadr, writedata, rd_ready,
    output rd_valid, rd_addr, rd_data, count,
    output overflow, store_count, done, pass, fail
  );
endinterface

// File: rtl/store_monitor.sv
// Data-memory store checker: captures stores into a FWFT FIFO
// and folds the store stream into a sticky pass/fail verdict.
module store_monitor #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80
) (
  input  logic            clk,
  input  logic            reset,
  store_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          done_q, pass_q, fail_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   scnt_q, scnt_d;
  logic [63:0]   mem_q [DEPTH];

  logic store, full, pop, push;

  // Handshake qualifiers: a store only counts while running.
  always_comb begin
    store = bus.memwrite && (state_q == ST_RUN);
    full  = (count_q == CW'(DEPTH));
    pop   = (count_q != '0) && bus.rd_ready;
    push  = store && (!full || pop);
  end

  // Next-state for verdict, pointers, occupancy and counters.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q;
    scnt_d  = scnt_q;
    if (store) begin
      if (bus.dataadr == PASS_ADDR &&
          bus.writedata == PASS_DATA)
        state_d = ST_PASS;
      else if (bus.dataadr != ALLOW_ADDR)
        state_d = ST_FAIL;
      if (scnt_q != 16'hFFFF)
        scnt_d = scnt_q + 16'd1;
      if (full && !pop)
        ovf_d = 1'b1;
    end
  end

  // Verdict FSM with registered done/pass/fail.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d != ST_RUN);
      pass_q  <= (state_d == ST_PASS);
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  // FIFO pointers, occupancy and sticky/saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      scnt_q  <= scnt_d;
    end
  end

  // Record storage; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= {bus.dataadr, bus.writedata};
  end

  assign bus.rd_valid    = (count_q != '0);
  assign bus.rd_addr     = bus.rd_valid ? mem_q[rptr_q][63:32] : 32'd0;
  assign bus.rd_data     = bus.rd_valid ? mem_q[rptr_q][31:0] : 32'd0;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.store_count = scnt_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Hardware checker on the processor's data-memory write port: the receiving end of the memwrite/dataadr/writedata store stream driven by top.
- Captures every store into a small FIFO that a host or debug reader drains over a valid/ready handshake.
- Classifies the store stream into a sticky pass/fail verdict, so self-checking runs need no simulator-side monitor.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- PASS_ADDR, 84, store address that signals success when paired with PASS_DATA.
- PASS_DATA, 7, data value required at PASS_ADDR for success.
- ALLOW_ADDR, 80, the only non-terminating store address tolerated while running.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  store strobe from processor, sampled at rising clk.
- dataadr  input  32  store byte address.
- writedata  input  32  store data.
- rd_ready  input  1  reader accepts the head record this cycle.
- rd_valid  output  1  FIFO non-empty; head record presented.
- rd_addr  output  32  address of the head record.
- rd_data  output  32  data of the head record.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a store was dropped because the FIFO was full.
- store_count  output  16  stores accepted by the checker; saturates at 16'hFFFF.
- done  output  1  sticky; verdict reached.
- pass  output  1  sticky; success verdict.
- fail  output  1  sticky; failure verdict.

Behaviour:
- Reset (synchronous, rising clk with reset=1):
  - state=RUN; FIFO empty; count=0; rd_valid=0.
  - overflow=0, store_count=0, done=0, pass=0, fail=0.
  - rd_addr and rd_data are 0 when empty.
  - Reset asserted mid-operation discards all FIFO contents and verdicts in that same edge.
- State machine, 2-bit encoding, states RUN / PASS / FAIL:
  - A store is any rising edge with memwrite=1.
  - In RUN:
    - store with dataadr==PASS_ADDR and writedata==PASS_DATA -> PASS.
    - else store with dataadr!=ALLOW_ADDR -> FAIL. This includes PASS_ADDR with wrong data.
    - else (dataadr==ALLOW_ADDR) stay in RUN.
  - PASS and FAIL are terminal until reset. Stores seen in a terminal state are neither captured nor counted.
  - Outputs: done = (state!=RUN); pass = (state==PASS); fail = (state==FAIL). All registered, asserted the cycle after the deciding edge.
- Capture:
  - Every store evaluated in RUN, including the terminating one, is pushed as {dataadr, writedata}.
  - The same store increments store_count.
- FIFO:
  - First-word-fall-through, circular buffer; pointers are $clog2(DEPTH) bits with natural wrap.
  - A pushed record is visible at rd_valid/rd_addr/rd_data on the cycle after its capture edge; it is never combinationally bypassed.
  - Pop occurs on an edge with rd_valid & rd_ready. rd_ready while empty is ignored.
  - Push while full and no pop that edge: record dropped, overflow set, store_count still increments, verdict still evaluated.
  - Push and pop on the same edge while full: push accepted, count unchanged.
  - Push and pop on the same edge otherwise: count unchanged, both take effect.
  - count is always equal to the number of valid entries; it never exceeds DEPTH.
- Arithmetic: address and data comparisons are full 32-bit equality. store_count saturates and does not wrap.

Test Plan:
- Hold reset 3 cycles, then release -> all outputs 0; rd_valid=0; count=0.
- Stores (80,3), (80,5), (84,7) on consecutive edges, rd_ready=0 -> pass=1, done=1, fail=0 one cycle after third store; count=3, store_count=3. Then rd_ready=1 -> records pop in order (80,3), (80,5), (84,7); rd_valid=0 afterward.
- Single store (88,1) -> fail=1, done=1 next cycle. Separate run with store (84,6) -> fail=1.
- Nine stores to (80,i), i=1..9, rd_ready=0, DEPTH=8:
  - count=8, overflow=1, store_count=9, state RUN.
  - Draining yields data 1..8.
  - Refill to full, then assert push and pop on the same edge -> count stays 8; new record appears last.
- After PASS, issue store (88,1) -> remains pass=1, fail=0, store_count unchanged, nothing captured.
- Assert reset for one cycle while count=5 and pass=1 -> next cycle count=0, rd_valid=0, all flags 0, state RUN.
